// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that funnels single bytes from NumReq
// requesters into a memory-mapped UART. Each byte polls the status register
// (UartBase+8, bit1 = TX FIFO full) until there is room, then writes the byte
// to the data register (UartBase+4).
// Optional feature: define UART_ARB_LINE_LOCK_EN to keep the grant on one
// requester until it writes 8'h0A or stays idle for LockTimeout cycles.
module uart_tx_arbiter #(
   parameter int unsigned NumReq      = 4,
   parameter logic [31:0] UartBase    = 32'h0,
   parameter int unsigned LockTimeout = 256
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumReq-1:0]   req_valid_i,
   input  logic [NumReq*8-1:0] req_data_i,
   output logic [NumReq-1:0]   req_ready_o,
   output logic                uart_req_o,
   output logic [31:0]         uart_addr_o,
   output logic                uart_we_o,
   output logic [3:0]          uart_be_o,
   output logic [31:0]         uart_wdata_o,
   input  logic                uart_rvalid_i,
   input  logic [31:0]         uart_rdata_i,
   output logic [2:0]          grant_idx_o,
   output logic                busy_o
);

   localparam int unsigned IdxW   = 3;
   localparam int unsigned MaxReq = 8;
   localparam int unsigned TmoW   = 16;

   typedef enum logic [2:0] {IDLE, POLL, WAIT_ST, WRITE, WAIT_WR} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   grant_idx_q, grant_idx_d;
   logic [7:0]        byte_q, byte_d;
   logic              uart_req_q, uart_req_d;
   logic              uart_we_q, uart_we_d;
   logic [3:0]        uart_be_q, uart_be_d;
   logic [31:0]       uart_addr_q, uart_addr_d;
   logic [31:0]       uart_wdata_q, uart_wdata_d;
   logic              busy_q, busy_d;

   logic [MaxReq-1:0] valid8;
   logic [MaxReq-1:0] eligible;
   logic              found;
   logic [IdxW-1:0]   win_idx;
   logic [3:0]        cand;

   // Only the FIFO-full bit of the status word is meaningful.
   logic unused_bits;
   assign unused_bits = ^{uart_rdata_i[31:2], uart_rdata_i[0], 32'(LockTimeout)};

   assign valid8 = MaxReq'(req_valid_i);

`ifdef UART_ARB_LINE_LOCK_EN
   logic            lock_q, lock_d;
   logic [TmoW-1:0] tmo_q, tmo_d;

   // Line lock: set after a non-newline byte, cleared by newline or idle timeout.
   always_comb begin
      lock_d = lock_q;
      tmo_d  = '0;
      if (state_q == WAIT_WR && uart_rvalid_i) begin
         lock_d = (byte_q != 8'h0A);
      end else if (state_q == IDLE && lock_q && !valid8[grant_idx_q]) begin
         if (tmo_q == TmoW'(LockTimeout - 1)) begin
            lock_d = 1'b0;
         end else begin
            tmo_d = tmo_q + TmoW'(1);
         end
      end
   end

   // Lock state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q <= 1'b0;
         tmo_q  <= '0;
      end else begin
         lock_q <= lock_d;
         tmo_q  <= tmo_d;
      end
   end
`endif

   // Round-robin search upward from rr_ptr with wrap at NumReq.
   always_comb begin
      eligible = valid8;
`ifdef UART_ARB_LINE_LOCK_EN
      if (lock_q) begin
         eligible = valid8 & (MaxReq'(1) << grant_idx_q);
      end
`endif
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         cand = 4'({1'b0, rr_ptr_q}) + 4'(i);
         if (cand >= 4'(NumReq)) begin
            cand = cand - 4'(NumReq);
         end
         if (!found && eligible[cand[IdxW-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[IdxW-1:0];
         end
      end
   end

   // Accept strobe must be same-cycle with the grant decision.
   assign req_ready_o = (state_q == IDLE && found && !rst_i) ?
                        (NumReq'(1) << win_idx) : '0;

   // Next-state, grant bookkeeping and byte capture.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_idx_d = grant_idx_q;
      byte_d      = byte_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = POLL;
               grant_idx_d = win_idx;
               rr_ptr_d    = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
               for (int unsigned k = 0; k < NumReq; k++) begin
                  if (win_idx == IdxW'(k)) begin
                     byte_d = req_data_i[8*k +: 8];
                  end
               end
            end
         end
         POLL:    state_d = WAIT_ST;
         WAIT_ST: begin
            if (uart_rvalid_i) begin
               state_d = uart_rdata_i[1] ? POLL : WRITE;
            end
         end
         WRITE:   state_d = WAIT_WR;
         WAIT_WR: begin
            if (uart_rvalid_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus and busy outputs decoded from the next state so they register in step.
   always_comb begin
      uart_req_d   = 1'b0;
      uart_we_d    = 1'b0;
      uart_be_d    = 4'h0;
      uart_addr_d  = 32'h0;
      uart_wdata_d = 32'h0;
      busy_d       = (state_d != IDLE);
      case (state_d)
         POLL: begin
            uart_req_d  = 1'b1;
            uart_be_d   = 4'hF;
            uart_addr_d = UartBase + 32'd8;
         end
         WRITE: begin
            uart_req_d   = 1'b1;
            uart_we_d    = 1'b1;
            uart_be_d    = 4'h1;
            uart_addr_d  = UartBase + 32'd4;
            uart_wdata_d = {24'h0, byte_d};
         end
         default: ;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_idx_q  <= '0;
         byte_q       <= '0;
         uart_req_q   <= 1'b0;
         uart_we_q    <= 1'b0;
         uart_be_q    <= 4'h0;
         uart_addr_q  <= 32'h0;
         uart_wdata_q <= 32'h0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_idx_q  <= grant_idx_d;
         byte_q       <= byte_d;
         uart_req_q   <= uart_req_d;
         uart_we_q    <= uart_we_d;
         uart_be_q    <= uart_be_d;
         uart_addr_q  <= uart_addr_d;
         uart_wdata_q <= uart_wdata_d;
         busy_q       <= busy_d;
      end
   end

   assign uart_req_o   = uart_req_q;
   assign uart_we_o    = uart_we_q;
   assign uart_be_o    = uart_be_q;
   assign uart_addr_o  = uart_addr_q;
   assign uart_wdata_o = uart_wdata_q;
   assign grant_idx_o  = grant_idx_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: UART responder, arbitration reference model,
// byte scoreboard, directed vector table and randomized traffic.
// Lock scenarios run when UART_ARB_LINE_LOCK_EN is defined.
module tb_uart_tx_arbiter;

   localparam int unsigned NR   = 4;
   localparam logic [31:0] BASE = 32'h4000_1000;
   localparam int unsigned LT   = 16;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [NR-1:0]     req_valid_i = '0;
   logic [NR*8-1:0]   req_data_i = {8'h44, 8'h43, 8'h42, 8'h41};
   logic [NR-1:0]     req_ready_o;
   logic              uart_req_o;
   logic [31:0]       uart_addr_o;
   logic              uart_we_o;
   logic [3:0]        uart_be_o;
   logic [31:0]       uart_wdata_o;
   logic              uart_rvalid_i = 1'b0;
   logic [31:0]       uart_rdata_i = '0;
   logic [2:0]        grant_idx_o;
   logic              busy_o;

   uart_tx_arbiter #(.NumReq(NR), .UartBase(BASE), .LockTimeout(LT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
      .uart_req_o(uart_req_o), .uart_addr_o(uart_addr_o), .uart_we_o(uart_we_o),
      .uart_be_o(uart_be_o), .uart_wdata_o(uart_wdata_o),
      .uart_rvalid_i(uart_rvalid_i), .uart_rdata_i(uart_rdata_i),
      .grant_idx_o(grant_idx_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference / scoreboard state
   int          ref_rr = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] stat_q[$];
   bit          rand_full = 1'b0;
   logic        next_rvalid = 1'b0;
   logic [31:0] next_rdata = '0;
   int          n_rd = 0;
   int          n_wr = 0;
   logic [7:0]  wr_log[$];
   int          wr_cyc[$];
   logic [NR-1:0] ready_or = '0;
   int          idle_cnt = 0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired (t=%0t)", nm, $time);
   endfunction

   // Winner by the round-robin rule: first valid index at or after ref_rr, wrapping.
   function automatic int model_winner(logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) begin
         if (v[(ref_rr + i) % NR]) return (ref_rr + i) % NR;
      end
      return -1;
   endfunction

   always @(posedge clk_i) cyc <= cyc + 1;

   // UART device: answers every request one cycle later.
   always @(posedge clk_i) begin
      #1;
      uart_rvalid_i = next_rvalid;
      uart_rdata_i  = next_rdata;
   end

   // Monitor: arbitration model, bus protocol and byte scoreboard.
   always @(negedge clk_i) begin
      int w;
      int g;
      if (rst_i) begin
         ref_rr      = 0;
         exp_q.delete();
         next_rvalid = 1'b0;
         next_rdata  = '0;
      end else begin
         if (busy_o) begin
            check("ready_while_busy", 32'(req_ready_o), 32'h0);
         end else begin
`ifndef UART_ARB_LINE_LOCK_EN
            w = model_winner(req_valid_i);
            check("rr_grant", 32'(req_ready_o), (w < 0) ? 32'h0 : (32'h1 << w));
`endif
            if (req_ready_o == '0) idle_cnt++;
         end
         if (req_ready_o != '0) begin
            check("ready_onehot", 32'($countones(req_ready_o)), 32'd1);
            g = 0;
            for (int i = 0; i < NR; i++) if (req_ready_o[i]) g = i;
            exp_q.push_back(req_data_i[8*g +: 8]);
            ref_rr   = (g + 1) % NR;
            ready_or = ready_or | req_ready_o;
         end
         if (uart_req_o) begin
            if (uart_we_o) begin
               check("wr_addr", uart_addr_o, BASE + 32'd4);
               check("wr_be", 32'(uart_be_o), 32'h1);
               check("wr_upper", 32'(uart_wdata_o[31:8]), 32'h0);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_write: wdata %h with no granted byte pending", uart_wdata_o);
               end else begin
                  check("wr_byte", 32'(uart_wdata_o[7:0]), 32'(exp_q.pop_front()));
               end
               wr_log.push_back(uart_wdata_o[7:0]);
               wr_cyc.push_back(cyc);
               n_wr++;
               next_rdata = $urandom;
            end else begin
               check("rd_addr", uart_addr_o, BASE + 32'd8);
               check("rd_be", 32'(uart_be_o), 32'hF);
               check("rd_wdata", uart_wdata_o, 32'h0);
               n_rd++;
               if (stat_q.size() != 0) next_rdata = stat_q.pop_front();
               else if (rand_full)     next_rdata = ($urandom & ~32'h2) | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0);
               else                    next_rdata = 32'h0;
            end
            next_rvalid = 1'b1;
         end else begin
            check("bus_idle", {uart_we_o, 3'b0, uart_be_o, uart_addr_o[23:0]} | uart_wdata_o, 32'h0);
            next_rvalid = 1'b0;
         end
      end
   end

   task automatic check_all_zero(string tag);
      check({tag, "_ready"}, 32'(req_ready_o), 32'h0);
      check({tag, "_req"},   32'(uart_req_o), 32'h0);
      check({tag, "_addr"},  uart_addr_o, 32'h0);
      check({tag, "_we_be"}, 32'({uart_we_o, uart_be_o}), 32'h0);
      check({tag, "_wdata"}, uart_wdata_o, 32'h0);
      check({tag, "_gidx"},  32'(grant_idx_o), 32'h0);
      check({tag, "_busy"},  32'(busy_o), 32'h0);
   endtask

   task automatic wait_grant(input int lim, input string nm, output logic [NR-1:0] rdy);
      rdy = '0;
      for (int t = 0; t < lim; t++) begin
         @(negedge clk_i);
         if (req_ready_o != '0) begin
            rdy = req_ready_o;
            return;
         end
      end
      fail_now(nm);
   endtask

   task automatic wait_idle(input int lim, input string nm);
      for (int t = 0; t < lim; t++) begin
         @(negedge clk_i);
         if (!busy_o) return;
      end
      fail_now(nm);
   endtask

   task automatic pulse_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      req_valid_i = '0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
   endtask

   typedef struct {
      logic [NR-1:0] valid;
      int            nfull;
      logic [NR-1:0] exp_ready;
      logic [7:0]    exp_byte;
   } vec_t;

   vec_t vec[12];

   initial begin
      logic [NR-1:0] rdy;
      int rd0, wr0, base, g0;

      vec[0]  = '{4'b1111, 0, 4'b0001, 8'h41};
      vec[1]  = '{4'b1111, 0, 4'b0010, 8'h42};
      vec[2]  = '{4'b1111, 0, 4'b0100, 8'h43};
      vec[3]  = '{4'b1111, 0, 4'b1000, 8'h44};
      vec[4]  = '{4'b1111, 0, 4'b0001, 8'h41};
      vec[5]  = '{4'b1111, 3, 4'b0010, 8'h42};
      vec[6]  = '{4'b0001, 0, 4'b0001, 8'h41};
      vec[7]  = '{4'b1001, 0, 4'b1000, 8'h44};
      vec[8]  = '{4'b0110, 1, 4'b0010, 8'h42};
      vec[9]  = '{4'b0011, 0, 4'b0001, 8'h41};
      vec[10] = '{4'b1100, 2, 4'b0100, 8'h43};
      vec[11] = '{4'b1101, 0, 4'b1000, 8'h44};

      // Reset holds everything at zero even with requests pending.
      req_valid_i = 4'b1111;
      repeat (2) @(negedge clk_i);
      check_all_zero("in_reset");
      @(posedge clk_i); #1;
      req_valid_i = '0;
      rst_i = 1'b0;

`ifndef UART_ARB_LINE_LOCK_EN
      // Directed vector table.
      for (int i = 0; i < 12; i++) begin
         @(posedge clk_i); #1;
         rd0 = n_rd;
         wr0 = n_wr;
         for (int k = 0; k < vec[i].nfull; k++) stat_q.push_back(32'h2);
         req_valid_i = vec[i].valid;
         wait_grant(20, $sformatf("vec%0d_grant", i), rdy);
         check($sformatf("vec%0d_ready", i), 32'(rdy), 32'(vec[i].exp_ready));
         @(posedge clk_i); #1;
         req_valid_i = '0;
         wait_idle(100, $sformatf("vec%0d_idle", i));
         @(posedge clk_i); #1;
         check($sformatf("vec%0d_reads", i), 32'(n_rd - rd0), 32'(vec[i].nfull + 1));
         check($sformatf("vec%0d_writes", i), 32'(n_wr - wr0), 32'd1);
         check($sformatf("vec%0d_byte", i), 32'(wr_log[$]), 32'(vec[i].exp_byte));
      end

      // Randomized traffic against the reference model.
      rand_full = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk_i); #1;
         req_valid_i = NR'($urandom);
         req_data_i  = $urandom;
      end
      req_valid_i = '0;
      wait_idle(200, "rand_drain");
      rand_full = 1'b0;
      @(posedge clk_i); #1;
      check("rand_pending", 32'(exp_q.size()), 32'd0);
      req_data_i = {8'h44, 8'h43, 8'h42, 8'h41};
`endif

      // Reset while waiting on status: abort, restart from req0, no stale write.
      @(posedge clk_i); #1;
      for (int k = 0; k < 6; k++) stat_q.push_back(32'h2);
      req_valid_i = 4'b0010;
      begin
         bit seen = 1'b0;
         for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk_i);
            if (uart_req_o) seen = 1'b1;
         end
         if (!seen) fail_now("rst_poll_seen");
      end
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      req_valid_i = 4'b1111;
      #1;
      check_all_zero("mid_reset");
      wr0 = n_wr;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      stat_q.delete();
      wait_grant(20, "post_rst_grant", rdy);
      check("post_rst_ready", 32'(rdy), 32'h1);
      @(posedge clk_i); #1;
      req_valid_i = '0;
      wait_idle(60, "post_rst_idle");
      @(posedge clk_i); #1;
      check("post_rst_writes", 32'(n_wr - wr0), 32'd1);
      check("post_rst_byte", 32'(wr_log[$]), 32'h41);

      // Single requester: back-to-back bytes at the minimum spacing.
      ready_or = '0;
      wr0  = n_wr;
      base = wr_log.size();
      g0   = 0;
      req_data_i[23:16] = 8'h50;
      req_valid_i = 4'b0100;
      for (int n = 0; n < 10; n++) begin
         wait_grant(60, $sformatf("single_grant%0d", n), rdy);
         if (n == 0) g0 = cyc;
         @(posedge clk_i); #1;
         req_data_i[23:16] = 8'(8'h51 + n);
         if (n == 9) req_valid_i = '0;
      end
      wait_idle(60, "single_idle");
      @(posedge clk_i); #1;
      check("single_writes", 32'(n_wr - wr0), 32'd10);
      check("single_ready_or", 32'(ready_or), 32'h4);
      if (wr_log.size() >= base + 10) begin
         check("single_latency", 32'(wr_cyc[base] - g0), 32'd3);
         for (int j = 0; j < 10; j++) begin
            check($sformatf("single_byte%0d", j), 32'(wr_log[base + j]), 32'(8'h50 + j));
            if (j > 0) check($sformatf("single_gap%0d", j), 32'(wr_cyc[base + j] - wr_cyc[base + j - 1]), 32'd5);
         end
      end

`ifdef UART_ARB_LINE_LOCK_EN
      // Line lock: "ab\n" from req0 goes out before req1's byte.
      pulse_reset();
      base = wr_log.size();
      req_data_i = {8'h00, 8'h00, 8'h31, 8'h61};
      req_valid_i = 4'b0011;
      for (int n = 0; n < 3; n++) begin
         wait_grant(30, $sformatf("lock_grant%0d", n), rdy);
         check($sformatf("lock_ready%0d", n), 32'(rdy), 32'h1);
         @(posedge clk_i); #1;
         if (n == 0) req_data_i[7:0] = 8'h62;
         if (n == 1) req_data_i[7:0] = 8'h0A;
         if (n == 2) req_valid_i = 4'b0010;
      end
      wait_grant(30, "lock_grant_r1", rdy);
      check("lock_ready_r1", 32'(rdy), 32'h2);
      @(posedge clk_i); #1;
      req_valid_i = '0;
      wait_idle(40, "lock_idle");
      @(posedge clk_i); #1;
      check("lock_count", 32'(wr_log.size() - base), 32'd4);
      if (wr_log.size() >= base + 4) begin
         check("lock_b0", 32'(wr_log[base]),     32'h61);
         check("lock_b1", 32'(wr_log[base + 1]), 32'h62);
         check("lock_b2", 32'(wr_log[base + 2]), 32'h0A);
         check("lock_b3", 32'(wr_log[base + 3]), 32'h31);
      end

      // Lock timeout: req1 waits exactly LT idle cycles after req0 goes quiet.
      pulse_reset();
      req_data_i = {8'h00, 8'h00, 8'h31, 8'h61};
      req_valid_i = 4'b0011;
      wait_grant(30, "tmo_grant0", rdy);
      check("tmo_ready0", 32'(rdy), 32'h1);
      @(posedge clk_i); #1;
      req_valid_i = 4'b0010;
      idle_cnt = 0;
      wait_grant(LT + 40, "tmo_grant1", rdy);
      check("tmo_ready1", 32'(rdy), 32'h2);
      @(posedge clk_i); #1;
      check("tmo_idle_cycles", 32'(idle_cnt), 32'(LT));
      req_valid_i = '0;
      wait_idle(40, "tmo_idle");
      @(posedge clk_i); #1;
      check("tmo_byte", 32'(wr_log[$]), 32'h31);
`endif

      repeat (3) @(posedge clk_i);
      #1;
      check("final_pending", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
